// File: rtl/jesd_rx_stream_buffer.sv
// Receive-stream buffer: sync-aligned capture into a registered FWFT FIFO with overflow re-align.
// Define JESD_STREAM_FILL_STATS_EN to enable the max_fill high-water register.
module jesd_rx_stream_buffer #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned FW    = AW + 1
) (
    input  logic              user_clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              disarm,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              din_sync,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    input  logic              dout_rdy,
    output logic              dout_sync,
    output logic              dout_overflow,
    output logic [CNT_W-1:0]  overflow_cnt,
    output logic [FW-1:0]     fill,
    output logic [FW-1:0]     max_fill,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitSync = 2'd1,
        StRun      = 2'd2
    } state_e;

    localparam logic [FW-1:0]    FillFull = FW'(DEPTH);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    state_e            state_q, state_d;
    logic [DATA_W:0]   mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [FW-1:0]     head_cnt;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d;
    logic              dout_sync_q, dout_sync_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pop, can_write, wr_en, drop, arm_eff;

    always_comb begin
        arm_eff   = arm & ~disarm;
        pop       = dout_vld_q & dout_rdy;
        can_write = (fill_q != FillFull) | pop;
        wr_en     = din_vld & can_write &
                    ((state_q == StRun) | ((state_q == StWaitSync) & din_sync));
        drop      = din_vld & ~can_write & (state_q != StIdle);

        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        fill_d   = fill_q + FW'(wr_en) - FW'(pop);

        // Only words stored before this edge may reach the output register.
        head_cnt    = fill_q - FW'(pop);
        dout_vld_d  = (head_cnt != '0);
        dout_d      = dout_q;
        dout_sync_d = dout_sync_q;
        if (dout_vld_d) begin
            {dout_sync_d, dout_d} = mem_q[rd_ptr_d];
        end

        state_d = state_q;
        if (disarm) begin
            state_d = StIdle;
        end else if (arm || drop) begin
            state_d = StWaitSync;
        end else if (state_q == StWaitSync && wr_en) begin
            state_d = StRun;
        end

        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (arm_eff) begin
            ovf_d = 1'b0;
            cnt_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            dout_sync_q <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            dout_sync_q <= dout_sync_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked by fill and the pointers.
    always_ff @(posedge user_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {din_sync, din};
        end
    end

`ifdef JESD_STREAM_FILL_STATS_EN
    logic [FW-1:0] max_fill_q, max_fill_d;

    always_comb begin
        max_fill_d = max_fill_q;
        if (arm_eff) begin
            max_fill_d = '0;
        end else if (fill_d > max_fill_q) begin
            max_fill_d = fill_d;
        end
    end

    always_ff @(posedge user_clk) begin
        if (rst) begin
            max_fill_q <= '0;
        end else begin
            max_fill_q <= max_fill_d;
        end
    end

    assign max_fill = max_fill_q;
`else
    assign max_fill = '0;
`endif

    assign dout          = dout_q;
    assign dout_vld      = dout_vld_q;
    assign dout_sync     = dout_sync_q;
    assign dout_overflow = ovf_q;
    assign overflow_cnt  = cnt_q;
    assign fill          = fill_q;
    assign state         = state_q;

endmodule

// File: doc/jesd_rx_stream_buffer.md
# jesd_rx_stream_buffer

Parametrised single-clock receive-stream buffer. It sits between the JESD link transport output (wide sample word, valid strobe, sync marker) and user DSP logic. It adds:

- arm / sync-aligned capture start;
- a DEPTH-word FIFO with ready/valid backpressure;
- overflow detection with automatic re-alignment;
- a saturating overflow counter.

It is the generalised successor of the fixed 512-bit, free-running capture path and runs entirely in the user clock domain; any CDC happens upstream.

## Interface
Parameters:
- DATA_W, 512, sample word width in bits (multiple of 16).
- DEPTH, 16, FIFO depth in words; power of two, 4..1024.
- CNT_W, 16, overflow counter width.

Ports:
- user_clk  in  1  sole clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle pulse: clear sticky status, enter WAIT_SYNC.
- disarm  in  1  one-cycle pulse: return to IDLE (FIFO contents retained).
- din  in  DATA_W  link sample word.
- din_vld  in  1  din qualifier.
- din_sync  in  1  sync/frame marker, meaningful only with din_vld.
- dout  out  DATA_W  buffered word.
- dout_vld  out  1  dout holds a valid word.
- dout_rdy  in  1  consumer accepts dout when dout_vld & dout_rdy.
- dout_sync  out  1  stored din_sync for the word on dout.
- dout_overflow  out  1  sticky: at least one word dropped since arm/reset.
- overflow_cnt  out  CNT_W  dropped-word count, saturating at all-ones.
- fill  out  $clog2(DEPTH)+1  words currently stored, 0..DEPTH.
- max_fill  out  $clog2(DEPTH)+1  high-water mark (see Configuration).
- state  out  2  0=IDLE, 1=WAIT_SYNC, 2=RUN.

## Operation
- **IDLE:** din ignored. arm → WAIT_SYNC.
- **WAIT_SYNC:** words are discarded until a cycle with din_vld & din_sync. That word is written (if not full) and state → RUN. This guarantees the first stored word after arm carries dout_sync=1.
- **RUN:** every din_vld word is written with its din_sync bit stored alongside.
- **Write acceptance:** a write is accepted when fill<DEPTH, or when fill==DEPTH and a read (dout_vld & dout_rdy) occurs in the same cycle.
- **Overflow:** a din_vld word in RUN or WAIT_SYNC that cannot be accepted is dropped. On a drop:
  - dout_overflow ← 1;
  - overflow_cnt increments (saturating);
  - state → WAIT_SYNC, so streaming resumes only on the next sync marker with no misaligned words.
- **disarm:** any state → IDLE. Takes priority over arm in the same cycle.
- **arm while in RUN:** clears dout_overflow and overflow_cnt and goes to WAIT_SYNC. The FIFO is not flushed.
- **Reads** are independent of state; the FIFO drains in IDLE.
- **Simultaneous read and write:** fill is unchanged.
- **Pointers:** $clog2(DEPTH)-bit, natural wrap. Full/empty are derived from fill, never from pointer equality.
- **Storage:** DATA_W+1 bits per entry.

## Timing
- **Reset values:** state=IDLE, fill=0, max_fill=0, dout_vld=0, dout_sync=0, dout_overflow=0, overflow_cnt=0. dout is don't-care but must be deterministic (0).
- **Latency:** a word written on edge N is on dout with dout_vld=1 after edge N+1 when the FIFO was empty. Output is first-word-fall-through, registered.
- **Output hold:** dout, dout_sync and dout_vld hold while dout_vld & !dout_rdy.
- **Throughput:** one word per cycle sustained, in and out.
- **Reset mid-operation:** the FIFO is emptied on the next edge; in-flight words are lost and not counted as overflow.
- **Registered status:** fill, overflow_cnt and dout_overflow update on the edge of the causing event and are visible the following cycle.

## Configuration
- Macro: JESD_STREAM_FILL_STATS_EN.
- **Defined:** max_fill is a register tracking the maximum fill since reset or arm, updated each cycle as max(max_fill, fill_next).
- **Undefined:** the high-water logic is absent and max_fill is tied to 0. All other behaviour is identical.

## Test plan
- **Reset and idle:** DEPTH=16, hold dout_rdy=1, assert din_vld for 10 cycles in IDLE → fill stays 0, dout_vld never 1, all outputs at reset values.
- **Sync alignment:** arm; words 0..4 with din_sync=0, word 5 with din_sync=1, words 6..9 with din_sync=0, dout_rdy=1 → dout emits words 5..9 in order. First word has dout_sync=1, appears 1 cycle after its write; state=RUN.
- **Backpressure fill:** dout_rdy=0, RUN, 16 consecutive din_vld words → fill=16, no overflow. Then dout_rdy=1 → 16 words out back-to-back in order.
- **Overflow and re-sync:**
  - FIFO full, dout_rdy=0, 3 more din_vld words → overflow_cnt=1, dout_overflow=1, state=WAIT_SYNC; the 2 following words are also dropped → overflow_cnt=3.
  - Non-sync words are then discarded; the next sync word is stored first once space frees.
- **Full with simultaneous read/write:** fill=16, din_vld & dout_vld & dout_rdy every cycle for 20 cycles → no drops, fill stays 16, output order preserved.
- **Saturation and stats:** CNT_W=4, force 20 drops → overflow_cnt=15. With JESD_STREAM_FILL_STATS_EN, max_fill=16 after the full test and resets to 0 on arm; without the macro, max_fill=0 throughout.
